// File: rtl/cp0_timer_random.sv
// CP0 Count/Compare timer with multi-channel interrupts
// and the Random/Wired pair that feeds the TLBWR index.
module cp0_timer_random #(
  parameter int COUNT_W     = 32,
  parameter int COUNT_DIV   = 2,
  parameter int NUM_CMP     = 1,
  parameter int TLB_ENTRIES = 16,
  localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cp0_we,
  input  logic [7:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  input  logic               count_stall,
  output logic [NUM_CMP-1:0] timer_int,
  output logic               timer_int_any,
  output logic [IDX_W-1:0]   tlbwr_index,
  output logic [COUNT_W-1:0] cp0_count_out
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);
  localparam logic [IDX_W-1:0] RND_MAX = IDX_W'(TLB_ENTRIES - 1);

  localparam logic [7:0] A_COUNT  = 8'h48;
  localparam logic [7:0] A_CMP    = 8'h58;
  localparam logic [7:0] A_WIRED  = 8'h30;
  localparam logic [7:0] A_RANDOM = 8'h08;

  logic [COUNT_W-1:0] count_q, count_d, count_inc;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [NUM_CMP-1:0][COUNT_W-1:0] cmp_q, cmp_d;
  logic [NUM_CMP-1:0] tint_q, tint_d;
  logic [NUM_CMP-1:0] hit_q, hit_d;
  logic [NUM_CMP-1:0] cmp_we;
  logic [IDX_W-1:0]   wired_q, wired_d;
  logic [IDX_W-1:0]   rnd_q, rnd_d;
  logic               count_we, wired_we, bump;

  assign count_we  = cp0_we && (cp0_addr == A_COUNT);
  assign wired_we  = cp0_we && (cp0_addr == A_WIRED);
  assign count_inc = count_q + 1'b1;
  assign bump      = !count_we && !count_stall
                     && (div_q == DIV_MAX);

  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    if (count_we) begin
      count_d = cp0_wdata[COUNT_W-1:0];
      div_d   = '0;
    end else if (!count_stall) begin
      if (div_q == DIV_MAX) begin
        div_d   = '0;
        count_d = count_inc;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // hit_q marks "the last edge incremented Count onto Compare[k]"
  always_comb begin
    cmp_we = '0;
    cmp_d  = cmp_q;
    hit_d  = '0;
    tint_d = tint_q;
    for (int k = 0; k < NUM_CMP; k++) begin
      cmp_we[k] = cp0_we && (cp0_addr == 8'(A_CMP + k));
      hit_d[k]  = bump && !cmp_we[k]
                  && (count_inc == cmp_q[k]);
      if (cmp_we[k]) begin
        cmp_d[k]  = cp0_wdata[COUNT_W-1:0];
        tint_d[k] = 1'b0;
      end else begin
        tint_d[k] = tint_q[k] | hit_q[k];
      end
    end
  end

  always_comb begin
    wired_d = wired_q;
    rnd_d   = rnd_q;
    if (wired_we) begin
      wired_d = cp0_wdata[IDX_W-1:0];
      rnd_d   = RND_MAX;
    end else if (rnd_q <= wired_q) begin
      rnd_d = RND_MAX;
    end else begin
      rnd_d = rnd_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
      div_q   <= '0;
      cmp_q   <= '0;
      tint_q  <= '0;
      hit_q   <= '0;
      wired_q <= '0;
      rnd_q   <= RND_MAX;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      cmp_q   <= cmp_d;
      tint_q  <= tint_d;
      hit_q   <= hit_d;
      wired_q <= wired_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      A_COUNT:  cp0_rdata = 32'(count_q);
      A_WIRED:  cp0_rdata = 32'(wired_q);
      A_RANDOM: cp0_rdata = 32'(rnd_q);
      default:  cp0_rdata = '0;
    endcase
    for (int k = 0; k < NUM_CMP; k++) begin
      if (cp0_addr == 8'(A_CMP + k))
        cp0_rdata = 32'(cmp_q[k]);
    end
  end

  assign timer_int     = tint_q;
  assign timer_int_any = |tint_q;
  assign tlbwr_index   = rnd_q;
  assign cp0_count_out = count_q;

endmodule

// File: tb/tb_cp0_timer_random.sv
// Scoreboard bench for cp0_timer_random:
// COUNT_W=8, COUNT_DIV=2, NUM_CMP=2, TLB_ENTRIES=16.
module tb_cp0_timer_random;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cp0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        count_stall;
  logic [1:0]  timer_int;
  logic        timer_int_any;
  logic [3:0]  tlbwr_index;
  logic [7:0]  cp0_count_out;

  cp0_timer_random #(
    .COUNT_W(8), .COUNT_DIV(2),
    .NUM_CMP(2), .TLB_ENTRIES(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .cp0_we(cp0_we),
    .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata),
    .count_stall(count_stall),
    .timer_int(timer_int),
    .timer_int_any(timer_int_any),
    .tlbwr_index(tlbwr_index),
    .cp0_count_out(cp0_count_out)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  localparam int RD  = 0;
  localparam int TI  = 1;
  localparam int IDX = 2;
  localparam int CNT = 3;
  localparam int ANY = 4;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input int sel,
                       input logic [7:0] a,
                       input logic [31:0] e);
    sb_t it;
    logic [31:0] obs;
    sb.push_back('{tag, sel, e});
    cp0_addr = a;
    #1;
    it = sb.pop_front();
    case (it.sel)
      RD:      obs = cp0_rdata;
      TI:      obs = 32'(timer_int);
      IDX:     obs = 32'(tlbwr_index);
      CNT:     obs = 32'(cp0_count_out);
      default: obs = 32'(timer_int_any);
    endcase
    chk(it.tag, obs, it.exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d);
    cp0_we    = 1'b1;
    cp0_addr  = a;
    cp0_wdata = d;
    step(1);
    cp0_we    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn      = 1'b0;
    cp0_we      = 1'b0;
    cp0_addr    = 8'h00;
    cp0_wdata   = 32'h0;
    count_stall = 1'b0;
    step(3);
    resetn = 1'b1;
    probe("rst_count", CNT, 8'h00, 32'd0);
    probe("rst_rd_count", RD, 8'h48, 32'd0);
    probe("rst_tint", TI, 8'h00, 32'd0);
    probe("rst_random", IDX, 8'h00, 32'd15);
    step(10);
    probe("count_10cyc", RD, 8'h48, 32'd5);
    probe("random_10cyc", IDX, 8'h00, 32'd5);

    wr(8'h48, 32'd0);
    wr(8'h58, 32'd3);
    wr(8'h59, 32'd6);
    step(4);
    probe("cnt_at3", CNT, 8'h00, 32'd3);
    probe("tint_lat0", TI, 8'h00, 32'b00);
    step(1);
    probe("tint_ch0", TI, 8'h00, 32'b01);
    step(5);
    probe("cnt_at6", CNT, 8'h00, 32'd6);
    probe("tint_lat1", TI, 8'h00, 32'b01);
    step(1);
    probe("tint_ch1", TI, 8'h00, 32'b11);

    cp0_we    = 1'b1;
    cp0_wdata = 32'd200;
    probe("rd_old_cmp0", RD, 8'h58, 32'd3);
    step(1);
    cp0_we = 1'b0;
    probe("tint_clr0", TI, 8'h00, 32'b10);
    probe("rd_cmp0", RD, 8'h58, 32'd200);
    probe("rd_cmp1", RD, 8'h59, 32'd6);
    probe("rd_unmapped", RD, 8'h5A, 32'd0);
    probe("tint_any", ANY, 8'h00, 32'd1);

    wr(8'h58, 32'd9);
    wr(8'h48, 32'd9);
    step(2);
    probe("wr_eq_cnt", CNT, 8'h00, 32'd10);
    probe("wr_eq_noflag", TI, 8'h00, 32'b10);

    wr(8'h58, 32'd0);
    wr(8'h48, 32'h0000_01FF);
    probe("cnt_trunc", RD, 8'h48, 32'h0000_00FF);
    step(2);
    probe("wrap_cnt", CNT, 8'h00, 32'd0);
    probe("wrap_lat", TI, 8'h00, 32'b10);
    step(1);
    probe("wrap_flag", TI, 8'h00, 32'b11);

    wr(8'h48, 32'd4);
    step(1);
    count_stall = 1'b1;
    step(7);
    probe("stall_hold", CNT, 8'h00, 32'd4);
    count_stall = 1'b0;
    step(1);
    probe("stall_rel", CNT, 8'h00, 32'd5);

    wr(8'h48, 32'd20);
    wr(8'h58, 32'd22);
    step(3);
    probe("cmpclr_cnt", CNT, 8'h00, 32'd22);
    probe("cmpclr_pre", TI, 8'h00, 32'b10);
    wr(8'h58, 32'd22);
    probe("cmpclr_wins", TI, 8'h00, 32'b10);
    step(2);
    probe("cmpclr_stay", TI, 8'h00, 32'b10);

    wr(8'h30, 32'd4);
    probe("wired_rnd15", IDX, 8'h00, 32'd15);
    probe("rd_wired", RD, 8'h30, 32'd4);
    probe("rd_random", RD, 8'h08, 32'd15);
    step(11);
    probe("rnd_floor", IDX, 8'h00, 32'd4);
    step(1);
    probe("rnd_wrap", IDX, 8'h00, 32'd15);
    wr(8'h08, 32'd3);
    probe("rnd_ro", RD, 8'h08, 32'd14);
    step(4);
    wr(8'h30, 32'd4);
    probe("wired_prio", IDX, 8'h00, 32'd15);
    step(11);
    probe("rnd_eq_wired", IDX, 8'h00, 32'd4);
    wr(8'h30, 32'd4);
    probe("wired_at_eq", IDX, 8'h00, 32'd15);
    wr(8'h30, 32'd15);
    step(3);
    probe("wired15_hold", IDX, 8'h00, 32'd15);
    probe("rd_wired15", RD, 8'h30, 32'd15);

    wr(8'h48, 32'd7);
    step(1);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    probe("rst2_count", CNT, 8'h00, 32'd0);
    probe("rst2_cmp0", RD, 8'h58, 32'd0);
    probe("rst2_tint", TI, 8'h00, 32'd0);
    probe("rst2_random", IDX, 8'h00, 32'd15);
    step(1);
    probe("rst2_phase0", CNT, 8'h00, 32'd0);
    step(1);
    probe("rst2_phase1", CNT, 8'h00, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
